// File: rtl/picomem_pkg.sv
// Shared types and constants for the PicoMem-to-Wishbone bridge on mux port S3.
package picomem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] PICOMEM_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] S3_BASE           = 32'hC000_0000;
  localparam logic [31:0] S3_LAST           = 32'hFFFF_FFFF;

  // Reads carry no strobes, so they select all four byte lanes.
  function automatic logic [3:0] wb_sel(input logic [3:0] wstrb);
    return (wstrb == 4'h0) ? 4'hF : wstrb;
  endfunction

  // Word part of (addr - base) mod 2^32, borrowing from the dropped byte offset.
  function automatic logic [29:0] wb_word_addr(input logic [31:0] addr, input logic [31:0] base);
    logic borrow;
    borrow = (addr[1:0] < base[1:0]);
    return addr[31:2] - base[31:2] - {29'd0, borrow};
  endfunction

endpackage

// File: rtl/picomem_wb_timeout.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last allowed cycle.
module picomem_wb_timeout #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/picomem_wb_bridge.sv
// PicoMem slave to Wishbone B4 classic master bridge with bounded cycles.
// Define PICOWB_ERR_LOG_EN to add the sticky err_flag/err_addr log and clr_err.
module picomem_wb_bridge
  import picomem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = S3_BASE,
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = PICOMEM_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_s_valid,
  output logic        mem_s_ready,
  input  logic [31:0] mem_s_addr,
  input  logic [31:0] mem_s_wdata,
  input  logic [3:0]  mem_s_wstrb,
  output logic [31:0] mem_s_rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [29:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
`ifdef PICOWB_ERR_LOG_EN
  ,
  input  logic        clr_err,
  output logic        err_flag,
  output logic [31:0] err_addr
`endif
);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tmo_clr, tmo_en, tmo_expired;

  picomem_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    ready_d = 1'b0;
    rdata_d = 32'd0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_s_valid) begin
          cyc_d   = 1'b1;
          we_d    = |mem_s_wstrb;
          sel_d   = wb_sel(mem_s_wstrb);
          adr_d   = wb_word_addr(mem_s_addr, ADDR_BASE);
          dat_d   = mem_s_wdata;
          tmo_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // err outranks ack; a same-cycle ack outranks the timeout.
        if (wbm_err_i || wbm_ack_i) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          rdata_d = wbm_err_i ? ERR_RDATA : (we_q ? 32'd0 : wbm_dat_i);
          state_d = RESP;
        end else if (tmo_expired) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          rdata_d = ERR_RDATA;
          state_d = RESP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 30'd0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_s_ready = ready_q;
  assign mem_s_rdata = rdata_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_dat_o   = dat_q;

`ifdef PICOWB_ERR_LOG_EN
  logic [31:0] addr_q, addr_d;
  logic        err_flag_q, err_flag_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_event;

  always_comb begin
    addr_d     = (state_q == IDLE && mem_s_valid) ? mem_s_addr : addr_q;
    err_event  = (state_q == BUS) && (wbm_err_i || (!wbm_ack_i && tmo_expired));
    err_addr_d = err_event ? addr_q : err_addr_q;
    err_flag_d = clr_err ? 1'b0 : (err_event ? 1'b1 : err_flag_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 32'd0;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      addr_q     <= addr_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// Directed bench for picomem_wb_bridge with a read-data scoreboard (TIMEOUT=8).
module tb_picomem_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_s_valid;
  logic        mem_s_ready;
  logic [31:0] mem_s_addr;
  logic [31:0] mem_s_wdata;
  logic [3:0]  mem_s_wstrb;
  logic [31:0] mem_s_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int checks = 0;
  int errors = 0;
  int cyc_starts = 0;
  logic cyc_prev = 1'b0;
  logic [31:0] exp_q[$];

  picomem_wb_bridge #(
    .ADDR_BASE(32'hC000_0000),
    .TIMEOUT  (8),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_s_valid(mem_s_valid),
    .mem_s_ready(mem_s_ready),
    .mem_s_addr (mem_s_addr),
    .mem_s_wdata(mem_s_wdata),
    .mem_s_wstrb(mem_s_wstrb),
    .mem_s_rdata(mem_s_rdata),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i)
  );

  always #5 clk = ~clk;

  // Count Wishbone cycles by their rising cyc edge.
  always @(posedge clk) begin
    cyc_prev <= wbm_cyc_o;
    if (wbm_cyc_o && !cyc_prev) cyc_starts <= cyc_starts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic run_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int waits, input bit do_ack,
                         input bit do_err, input logic [31:0] dat, input logic [31:0] expd,
                         input int exp_lat, input int exp_cyc, input bit drop_valid);
    int lat;
    int cyc_cnt;
    bit got;
    logic [31:0] e;
    logic [29:0] exp_adr;
    exp_adr = 30'((addr - 32'hC000_0000) >> 2);
    exp_q.push_back(expd);
    mem_s_valid = 1'b1;
    mem_s_addr  = addr;
    mem_s_wdata = wdata;
    mem_s_wstrb = wstrb;
    lat = 1;
    tick();
    lat++;
    check({tag, " cyc"}, {31'd0, wbm_cyc_o}, 32'd1);
    check({tag, " stb"}, {31'd0, wbm_stb_o}, 32'd1);
    check({tag, " we"}, {31'd0, wbm_we_o}, {31'd0, (wstrb != 4'h0)});
    check({tag, " sel"}, {28'd0, wbm_sel_o}, {28'd0, (wstrb == 4'h0) ? 4'hF : wstrb});
    cyc_cnt = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (wbm_cyc_o) begin
        cyc_cnt++;
        check({tag, " adr held"}, {2'd0, wbm_adr_o}, {2'd0, exp_adr});
        check({tag, " dat held"}, wbm_dat_o, wdata);
        if (k == waits) begin
          wbm_ack_i = do_ack;
          wbm_err_i = do_err;
          wbm_dat_i = dat;
        end
      end
      tick();
      lat++;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (mem_s_ready) got = 1;
    end
    check({tag, " ready seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, " sb nonempty"}, {31'd0, (exp_q.size() > 0)}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check({tag, " rdata"}, mem_s_rdata, e);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " cyc cycles"}, cyc_cnt, exp_cyc);
      check({tag, " cyc dropped"}, {31'd0, wbm_cyc_o}, 32'd0);
    end
    if (drop_valid) begin
      mem_s_valid = 1'b0;
      tick();
      check({tag, " ready one cycle"}, {31'd0, mem_s_ready}, 32'd0);
      check({tag, " rdata cleared"}, mem_s_rdata, 32'd0);
      check({tag, " idle cyc"}, {31'd0, wbm_cyc_o}, 32'd0);
    end
  endtask

  int starts_before;

  initial begin
    reset = 1'b1;
    mem_s_valid = 1'b0;
    mem_s_addr = 32'd0;
    mem_s_wdata = 32'd0;
    mem_s_wstrb = 4'd0;
    wbm_dat_i = 32'd0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    tick();
    tick();
    check("reset cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("reset stb", {31'd0, wbm_stb_o}, 32'd0);
    check("reset ready", {31'd0, mem_s_ready}, 32'd0);
    check("reset rdata", mem_s_rdata, 32'd0);
    check("reset adr", {2'd0, wbm_adr_o}, 32'd0);
    check("reset sel_we", {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
    reset = 1'b0;
    tick();

    // Zero-wait read
    check("rd adr0", {2'd0, wbm_adr_o}, 32'd0);
    run_req("rd0", 32'hC000_0010, 32'd0, 4'h0, 0, 1, 0, 32'h1234_5678, 32'h1234_5678, 3, 1, 1);

    // Byte write with 3 wait states: writes return 0 even if dat_i is busy
    run_req("wr3", 32'hC000_0104, 32'h00AB_0000, 4'b0100, 3, 1, 0, 32'hFFFF_FFFF, 32'd0, 6, 4, 1);

    // Simultaneous ack+err: err wins
    run_req("ackerr", 32'hC000_0104, 32'd0, 4'h0, 0, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1, 1);

    // Plain err after one wait state
    run_req("err1", 32'hC000_0008, 32'd0, 4'h0, 1, 0, 1, 32'h5555_AAAA, 32'hDEAD_BEEF, 4, 2, 1);

    // Timeout: no ack for TIMEOUT=8 cycles
    run_req("tmo", 32'hC000_0200, 32'h0, 4'h0, 0, 0, 0, 32'd0, 32'hDEAD_BEEF, 10, 8, 1);
    starts_before = cyc_starts;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("late ack ready", {31'd0, mem_s_ready}, 32'd0);
    tick();
    check("late ack ready2", {31'd0, mem_s_ready}, 32'd0);
    check("late ack cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("late ack starts", cyc_starts, starts_before);

    // Back-to-back: valid stays high through RESP carrying the next request
    starts_before = cyc_starts;
    run_req("b2b_a", 32'hC000_0020, 32'd0, 4'h0, 0, 1, 0, 32'h1111_1111, 32'h1111_1111, 3, 1, 0);
    mem_s_addr = 32'hC000_0024;
    tick();
    check("b2b resp no accept", {31'd0, wbm_cyc_o}, 32'd0);
    check("b2b ready one cycle", {31'd0, mem_s_ready}, 32'd0);
    run_req("b2b_b", 32'hC000_0024, 32'd0, 4'h0, 0, 1, 0, 32'h2222_2222, 32'h2222_2222, 3, 1, 1);
    check("b2b wb cycles", cyc_starts - starts_before, 32'd2);

    // Reset in the middle of a bus cycle
    mem_s_valid = 1'b1;
    mem_s_addr = 32'hC000_0300;
    mem_s_wstrb = 4'h0;
    tick();
    check("rst mid cyc up", {31'd0, wbm_cyc_o}, 32'd1);
    mem_s_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst mid cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst mid stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rst mid ready", {31'd0, mem_s_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst no ready", {31'd0, mem_s_ready}, 32'd0);
    end

    // The bridge is back in IDLE and serves a fresh request normally
    run_req("post_rst", 32'hC000_0040, 32'd0, 4'h0, 2, 1, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 5, 3, 1);
    check("sb drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
